// File: rtl/prior_code_expander.sv
// prior_code_expander: turns buffered {none, y} priority codes back into a
// one-hot 8-bit line. Each decoded value is held on `a` for HOLD cycles.
// Codes queue in a small FIFO so the upstream encoder is never throttled
// by the hold time until the FIFO fills.
module prior_code_expander #(
   parameter int HOLD  = 4,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             y,
   input  logic                   none,
   output logic [7:0]             a,
   output logic                   a_valid,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0]    HOLD_LOAD = 4'(HOLD - 1);
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t        state_q, state_d;
   logic [3:0]    hold_q, hold_d;
   logic [7:0]    a_q, a_d;
   logic          a_valid_q, a_valid_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]    mem_q [DEPTH];
   logic          push;
   logic          pop;
   logic [3:0]    head;

   // One-hot expansion of a stored code; an empty code expands to all zeros.
   function automatic logic [7:0] decode(input logic [3:0] code);
      logic [7:0] r;
      r = 8'h00;
      if (!code[3]) r[code[2:0]] = 1'b1;
      return r;
   endfunction

   assign in_ready = (count_q != FULL);
   assign busy     = (state_q == S_HOLD) || (count_q != '0);
   assign a        = a_q;
   assign a_valid  = a_valid_q;
   assign count    = count_q;
   assign head     = mem_q[rd_ptr_q];

   // Slot sequencer: decide when to pop the FIFO head and what `a` shows next.
   // Pop decisions look only at the registered count, so a code pushed on the
   // same edge is picked up one cycle later.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      a_d       = a_q;
      a_valid_d = a_valid_q;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            a_d       = 8'h00;
            a_valid_d = 1'b0;
            if (count_q != '0) begin
               pop       = 1'b1;
               a_d       = decode(head);
               a_valid_d = 1'b1;
               hold_d    = HOLD_LOAD;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_q != 4'd0) begin
               hold_d = hold_q - 4'd1;
            end else if (count_q != '0) begin
               // Back-to-back slot: reload without an idle gap.
               pop    = 1'b1;
               a_d    = decode(head);
               hold_d = HOLD_LOAD;
            end else begin
               a_d       = 8'h00;
               a_valid_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO bookkeeping: pointer advance and occupancy for push/pop.
   always_comb begin
      push     = in_valid && in_ready;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   // Control and output registers; reset aborts any slot in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         hold_q    <= 4'd0;
         a_q       <= 8'h00;
         a_valid_q <= 1'b0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         a_q       <= a_d;
         a_valid_q <= a_valid_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are don't-care until the pointers say otherwise.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {none, y};
   end

endmodule

// File: tb/tb_prior_code_expander.sv
// Bench for prior_code_expander: three instances (HOLD = 4, 2, 1) share one
// input stream; a queue-and-countdown reference model predicts every output.
module tb_prior_code_expander;
   localparam int DEPTH = 4;
   localparam int NI    = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] y;
   logic       none;
   logic       in_ready_o [NI];
   logic [7:0] a_o        [NI];
   logic       a_valid_o  [NI];
   logic       busy_o     [NI];
   logic [2:0] count_o    [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      prior_code_expander #(
         .HOLD ((g == 0) ? 4 : ((g == 1) ? 2 : 1)),
         .DEPTH(DEPTH)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .in_valid(in_valid),
         .in_ready(in_ready_o[g]),
         .y       (y),
         .none    (none),
         .a       (a_o[g]),
         .a_valid (a_valid_o[g]),
         .busy    (busy_o[g]),
         .count   (count_o[g])
      );
   end

   // Reference model: list of waiting codes plus the code on display and
   // the number of cycles it still has to stay there.
   logic [3:0] m_q   [NI][16];
   int         m_n   [NI];
   logic       m_v   [NI];
   logic [3:0] m_cur [NI];
   int         m_rem [NI];

   function automatic int hold_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
   endfunction

   function automatic logic [7:0] expand(input logic [3:0] c);
      if (c[3]) return 8'h00;
      return 8'(2 ** c[2:0]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_n[k] = 0; m_v[k] = 1'b0; m_cur[k] = 4'h0; m_rem[k] = 0;
      end
   endtask

   task automatic model_edge();
      logic acc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < NI; k++) begin
         acc = in_valid && (m_n[k] < DEPTH);
         if (m_v[k] && m_rem[k] > 1) begin
            m_rem[k] = m_rem[k] - 1;
         end else if (m_n[k] > 0) begin
            m_cur[k] = m_q[k][0];
            for (int i = 0; i < 15; i++) m_q[k][i] = m_q[k][i+1];
            m_n[k]   = m_n[k] - 1;
            m_v[k]   = 1'b1;
            m_rem[k] = hold_of(k);
         end else begin
            m_v[k] = 1'b0;
         end
         if (acc) begin
            m_q[k][m_n[k]] = {none, y};
            m_n[k] = m_n[k] + 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d.a", k),        32'(a_o[k]),        32'(m_v[k] ? expand(m_cur[k]) : 8'h00));
         check($sformatf("u%0d.a_valid", k),  32'(a_valid_o[k]),  32'(m_v[k]));
         check($sformatf("u%0d.busy", k),     32'(busy_o[k]),     32'(m_v[k] || (m_n[k] != 0)));
         check($sformatf("u%0d.count", k),    32'(count_o[k]),    32'(m_n[k]));
         check($sformatf("u%0d.in_ready", k), 32'(in_ready_o[k]), 32'(m_n[k] != DEPTH));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic v, input logic n, input logic [2:0] yy);
      in_valid = v; none = n; y = yy;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 3'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      cycle();

      // Single code y=3: visible one edge after acceptance, held HOLD cycles.
      drive(1'b1, 1'b0, 3'd3);
      cycle();
      drive(1'b0, 1'b0, 3'd0);
      cycle();
      check("t1.a_08",    32'(a_o[0]), 32'h08);
      check("t1.a_valid", 32'(a_valid_o[0]), 32'h1);
      for (int i = 0; i < 8; i++) cycle();
      check("t1.idle_busy", 32'(busy_o[0]), 32'h0);

      // Back-to-back y=7, y=0, none.
      drive(1'b1, 1'b0, 3'd7); cycle();
      drive(1'b1, 1'b0, 3'd0); cycle();
      drive(1'b1, 1'b1, 3'd5); cycle();
      check("t2.u1_a_80", 32'(a_o[1]), 32'h80);
      drive(1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 16; i++) cycle();

      // Overfill while slots are in progress; extra pushes must be dropped.
      for (int i = 0; i < DEPTH + 3; i++) begin
         drive(1'b1, 1'b0, 3'(i + 1));
         cycle();
         if (i == 4) begin
            check("t3.full_count", 32'(count_o[0]), 32'd4);
            check("t3.full_ready", 32'(in_ready_o[0]), 32'd0);
         end
      end
      drive(1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 40; i++) cycle();

      // Random traffic: simultaneous push/pop and pointer wrap.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
         cycle();
      end
      drive(1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 40; i++) cycle();

      // Asynchronous reset in the middle of a slot with codes queued.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 3'(7 - i));
         cycle();
      end
      drive(1'b0, 1'b0, 3'd0);
      check("t5.pre_count", 32'(count_o[0]), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("t5.u%0d.a", k),       32'(a_o[k]),       32'h0);
         check($sformatf("t5.u%0d.a_valid", k), 32'(a_valid_o[k]), 32'h0);
         check($sformatf("t5.u%0d.count", k),   32'(count_o[k]),   32'h0);
      end
      model_reset();
      check_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) cycle();

      // HOLD=1 walk: one-hot steps one position per cycle.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 3'(i % 8));
         cycle();
         if (i >= 1) begin
            check($sformatf("t6.walk%0d", i), 32'(a_o[2]), 32'(1 << ((i - 1) % 8)));
            check($sformatf("t6.ready%0d", i), 32'(in_ready_o[2]), 32'h1);
         end
      end
      drive(1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 60; i++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
